load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, giving data width; legal values 32 and 64.
REQ-002 The block SHALL have parameter ADDR_W, default 32, giving address width.
REQ-003 The block SHALL have parameter TIMEOUT, default 255, giving the maximum cycles spent in REQ+WAIT before abort; legal range 1..65535.
REQ-004 Ports SHALL be:
- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_is_store  in  1  1 = store, 0 = load.
- req_funct3  in  3  RISC-V LOAD/STORE funct3.
- req_addr  in  ADDR_W  byte address (rs1 + imm).
- req_wdata  in  XLEN  store data (rs2).
- req_rd  in  5  load destination register.
- mem_valid  out  1  memory request.
- mem_ready  in  1  memory accepts request.
- mem_addr  out  ADDR_W  XLEN-aligned address.
- mem_we  out  1  write enable.
- mem_wstrb  out  XLEN/8  byte strobes.
- mem_wdata  out  XLEN  lane-positioned store data.
- mem_rvalid  in  1  read data / write ack.
- mem_rdata  in  XLEN  read data.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rd  out  5  echoed req_rd; 0 for stores.
- rsp_data  out  XLEN  extended load result; 0 for stores and errors.
- rsp_err  out  2  0 ok, 1 misaligned, 2 timeout, 3 illegal funct3.

Function
REQ-005 The FSM SHALL have states IDLE, REQ, WAIT, RESP; req_ready = (state == IDLE).
REQ-006 A request SHALL be accepted on the edge where req_valid && req_ready, and all request fields SHALL be latched then.
REQ-007 On acceptance with a legal, aligned access, the FSM SHALL go IDLE->REQ; with a misaligned or illegal access it SHALL go IDLE->RESP with no memory access.
REQ-008 Lane offset SHALL be req_addr[log2(XLEN/8)-1:0], and mem_addr SHALL be req_addr with those bits zeroed.
REQ-009 Legal funct3 values SHALL be:
- Loads: LB 000, LH 001, LW 010, LBU 100, LHU 101; plus LD 011 and LWU 110 only when XLEN=64.
- Stores: SB 000, SH 001, SW 010; plus SD 011 only when XLEN=64.
- All other values SHALL give rsp_err=3.
REQ-010 Halfword accesses SHALL be misaligned when addr[0]!=0, word when addr[1:0]!=0, and doubleword when addr[2:0]!=0; illegal funct3 SHALL take priority over misaligned.
REQ-011 In REQ, mem_valid SHALL be 1 and mem_addr/mem_we/mem_wstrb/mem_wdata SHALL be held stable until mem_ready; on mem_valid && mem_ready the FSM SHALL go to WAIT.
REQ-012 Store strobes SHALL be 1, 2, 4 or 8 contiguous ones shifted left by the lane offset; mem_wdata SHALL carry the store data shifted left by 8*offset, with unstrobed bytes at 0; loads SHALL drive mem_wstrb=0.
REQ-013 In WAIT, mem_rvalid SHALL move the FSM to RESP; for loads, mem_rdata SHALL be shifted right by 8*offset, truncated to the access size, and sign-extended (LB/LH/LW) or zero-extended (LBU/LHU/LWU) to XLEN; LD SHALL pass data through unmodified.
REQ-014 mem_rvalid SHALL be ignored in IDLE, REQ and RESP.
REQ-015 A cycle counter SHALL clear on acceptance and increment each cycle in REQ or WAIT; when it reaches TIMEOUT, the FSM SHALL go to RESP with rsp_err=2 and mem_valid SHALL deassert on that edge.
REQ-016 Timeout SHALL take priority over a simultaneous mem_ready or mem_rvalid.
REQ-017 In RESP, rsp_valid SHALL be 1 for exactly one cycle and then the FSM SHALL return to IDLE; there is no response backpressure.
REQ-018 rsp_rd, rsp_data and rsp_err SHALL be registered and valid only while rsp_valid=1.
REQ-019 Minimum latency SHALL be: acceptance at edge 0, mem_valid during cycle 1, mem_ready in cycle 1, mem_rvalid in cycle 2, rsp_valid in cycle 3.
REQ-020 Error latency SHALL be rsp_valid in the cycle after acceptance.
REQ-021 Back-to-back throughput SHALL be one request per 4 cycles at best, since req_ready is low from REQ through RESP.

Reset
REQ-022 While rst_n=0, regardless of clk, the state SHALL be IDLE, the counter 0, and all outputs 0 except req_ready=1.
REQ-023 Reset asserted mid-transaction SHALL abandon the transaction with no rsp_valid; a stale mem_rvalid after release SHALL be ignored per REQ-014.

Verification
REQ-024 XLEN=32, LB addr 0x103, mem_rdata 0x80FF1234, 0-wait memory -> rsp_valid 3 cycles after acceptance, rsp_data 0xFFFFFF80, rsp_err 0.
REQ-025 XLEN=32, SH addr 0x202, wdata 0x0000ABCD -> mem_addr 0x200, mem_wstrb 4'b1100, mem_wdata 0xABCD0000, mem_we 1, rsp_rd 0.
REQ-026 LW addr 0x101 -> no mem_valid, rsp_valid next cycle, rsp_err 1; funct3 011 with XLEN=32 -> rsp_err 3.
REQ-027 TIMEOUT=8, mem_ready held 0 -> mem_valid high 8 cycles, then rsp_err 2; a later mem_rvalid is ignored and the next request completes normally.
REQ-028 XLEN=64, LWU addr 0x14, mem_rdata 0xDEADBEEF_00000000 -> rsp_data 0x00000000_DEADBEEF; SD addr 0x18 -> mem_wstrb 8'hFF.
REQ-029 rst_n pulsed low while in WAIT -> outputs clear immediately, no rsp_valid, req_ready 1 after release.

Source files
------------

// File: rtl/load_store_unit_if.sv
// Request, memory and response signals of the load/store unit, bundled into one interface.
// The master modport is the LSU view. The slave modport is the core/memory view.
interface load_store_unit_if #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_is_store;
    logic [2:0]        req_funct3;
    logic [ADDR_W-1:0] req_addr;
    logic [XLEN-1:0]   req_wdata;
    logic [4:0]        req_rd;

    logic              mem_valid;
    logic              mem_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [XLEN/8-1:0] mem_wstrb;
    logic [XLEN-1:0]   mem_wdata;
    logic              mem_rvalid;
    logic [XLEN-1:0]   mem_rdata;

    logic              rsp_valid;
    logic [4:0]        rsp_rd;
    logic [XLEN-1:0]   rsp_data;
    logic [1:0]        rsp_err;

    modport master (
        input  req_valid, req_is_store, req_funct3, req_addr, req_wdata, req_rd,
        input  mem_ready, mem_rvalid, mem_rdata,
        output req_ready, mem_valid, mem_addr, mem_we, mem_wstrb, mem_wdata,
        output rsp_valid, rsp_rd, rsp_data, rsp_err
    );

    modport slave (
        output req_valid, req_is_store, req_funct3, req_addr, req_wdata, req_rd,
        output mem_ready, mem_rvalid, mem_rdata,
        input  req_ready, mem_valid, mem_addr, mem_we, mem_wstrb, mem_wdata,
        input  rsp_valid, rsp_rd, rsp_data, rsp_err
    );
endinterface

// File: rtl/load_store_unit.sv
// Single-outstanding RISC-V load/store unit: lane alignment, strobes, load extension and timeout.
// Uses a four-state FSM (IDLE, REQ, WAIT, RESP). Every output comes from a register.
module load_store_unit #(
    parameter int XLEN    = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255
) (
    input logic               clk,
    input logic               rst_n,
    load_store_unit_if.master bus
);
    localparam int STRB_W = XLEN / 8;
    localparam int OFF_W  = $clog2(STRB_W);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_e;
    typedef enum logic [1:0] {
        ERR_OK       = 2'd0,
        ERR_MISALIGN = 2'd1,
        ERR_TIMEOUT  = 2'd2,
        ERR_ILLEGAL  = 2'd3
    } err_e;

    state_e            state_q;
    logic [15:0]       cnt_q;
    logic              is_store_q;
    logic [2:0]        funct3_q;
    logic [OFF_W-1:0]  off_q;
    logic [4:0]        rd_q;
    logic              req_ready_q;
    logic              mem_valid_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [STRB_W-1:0] mem_wstrb_q;
    logic [XLEN-1:0]   mem_wdata_q;
    logic              rsp_valid_q;
    logic [4:0]        rsp_rd_q;
    logic [XLEN-1:0]   rsp_data_q;
    logic [1:0]        rsp_err_q;

    logic [OFF_W-1:0]  req_off;
    logic [ADDR_W-1:0] req_addr_aligned;
    logic              req_legal;
    logic              req_misaligned;
    logic [STRB_W-1:0] size_strb;
    logic [XLEN-1:0]   size_data;
    logic [STRB_W-1:0] req_strb;
    logic [XLEN-1:0]   req_wdata_lane;
    logic [XLEN-1:0]   rdata_shift;
    logic [XLEN-1:0]   load_data;
    logic [15:0]       cnt_inc;
    logic              timeout_hit;

    // NOTE: every signal assigned in always_comb gets a value on all paths (default first), otherwise a latch is inferred.
    always_comb begin
        req_off          = bus.req_addr[OFF_W-1:0];
        req_addr_aligned = bus.req_addr & ~ADDR_W'(STRB_W - 1);

        if (bus.req_is_store) begin
            req_legal = (bus.req_funct3 inside {3'b000, 3'b001, 3'b010}) ||
                        (bus.req_funct3 == 3'b011 && XLEN == 64);
        end else begin
            req_legal = (bus.req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}) ||
                        ((bus.req_funct3 inside {3'b011, 3'b110}) && XLEN == 64);
        end

        case (bus.req_funct3[1:0])
            2'd0: begin
                req_misaligned = 1'b0;
                size_strb      = STRB_W'(1);
                size_data      = XLEN'(bus.req_wdata[7:0]);
            end
            2'd1: begin
                req_misaligned = bus.req_addr[0];
                size_strb      = STRB_W'(3);
                size_data      = XLEN'(bus.req_wdata[15:0]);
            end
            2'd2: begin
                req_misaligned = |bus.req_addr[1:0];
                size_strb      = STRB_W'(15);
                size_data      = XLEN'(bus.req_wdata[31:0]);
            end
            default: begin
                req_misaligned = |bus.req_addr[2:0];
                size_strb      = '1;
                size_data      = bus.req_wdata;
            end
        endcase

        req_strb       = bus.req_is_store ? (size_strb << req_off) : '0;
        req_wdata_lane = bus.req_is_store ? (size_data << {req_off, 3'b000}) : '0;
    end

    // Load path: move the addressed lane down to bit 0, then truncate and extend it.
    always_comb begin
        rdata_shift = bus.mem_rdata >> {off_q, 3'b000};
        case (funct3_q)
            3'b000:  load_data = XLEN'($signed(rdata_shift[7:0]));
            3'b001:  load_data = XLEN'($signed(rdata_shift[15:0]));
            3'b010:  load_data = XLEN'($signed(rdata_shift[31:0]));
            3'b100:  load_data = XLEN'(rdata_shift[7:0]);
            3'b101:  load_data = XLEN'(rdata_shift[15:0]);
            3'b110:  load_data = XLEN'(rdata_shift[31:0]);
            default: load_data = rdata_shift;
        endcase
        cnt_inc     = cnt_q + 16'd1;
        timeout_hit = (cnt_inc == 16'(TIMEOUT));
    end

    // NOTE: sequential state uses non-blocking (<=) only, so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            is_store_q  <= 1'b0;
            funct3_q    <= '0;
            off_q       <= '0;
            rd_q        <= '0;
            req_ready_q <= 1'b1;
            mem_valid_q <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wstrb_q <= '0;
            mem_wdata_q <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rd_q    <= '0;
            rsp_data_q  <= '0;
            rsp_err_q   <= ERR_OK;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.req_valid) begin
                        is_store_q  <= bus.req_is_store;
                        funct3_q    <= bus.req_funct3;
                        off_q       <= req_off;
                        rd_q        <= bus.req_rd;
                        cnt_q       <= '0;
                        req_ready_q <= 1'b0;
                        mem_addr_q  <= req_addr_aligned;
                        mem_we_q    <= bus.req_is_store;
                        mem_wstrb_q <= req_strb;
                        mem_wdata_q <= req_wdata_lane;
                        if (!req_legal || req_misaligned) begin
                            state_q     <= RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_rd_q    <= bus.req_is_store ? 5'd0 : bus.req_rd;
                            rsp_data_q  <= '0;
                            rsp_err_q   <= req_legal ? ERR_MISALIGN : ERR_ILLEGAL;
                        end else begin
                            state_q     <= REQ;
                            mem_valid_q <= 1'b1;
                        end
                    end
                end
                REQ, WAIT: begin
                    cnt_q <= cnt_inc;
                    if (timeout_hit) begin
                        state_q     <= RESP;
                        mem_valid_q <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_rd_q    <= is_store_q ? 5'd0 : rd_q;
                        rsp_data_q  <= '0;
                        rsp_err_q   <= ERR_TIMEOUT;
                    end else if (state_q == REQ && bus.mem_ready) begin
                        state_q     <= WAIT;
                        mem_valid_q <= 1'b0;
                    end else if (state_q == WAIT && bus.mem_rvalid) begin
                        state_q     <= RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_rd_q    <= is_store_q ? 5'd0 : rd_q;
                        rsp_data_q  <= is_store_q ? '0 : load_data;
                        rsp_err_q   <= ERR_OK;
                    end
                end
                RESP: begin
                    state_q     <= IDLE;
                    req_ready_q <= 1'b1;
                    rsp_valid_q <= 1'b0;
                    rsp_rd_q    <= '0;
                    rsp_data_q  <= '0;
                    rsp_err_q   <= ERR_OK;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.mem_valid = mem_valid_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_wstrb = mem_wstrb_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rd    = rsp_rd_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_err   = rsp_err_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: a 32-bit instance (TIMEOUT=8) and a 64-bit instance
// share one stimulus set, and sel64 picks which instance is driven and observed.
module tb_load_store_unit;
    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic        sel64        = 1'b0;
    logic        req_valid    = 1'b0;
    logic        req_is_store = 1'b0;
    logic [2:0]  req_funct3   = '0;
    logic [31:0] req_addr     = '0;
    logic [63:0] req_wdata    = '0;
    logic [4:0]  req_rd       = '0;
    logic        mem_ready    = 1'b0;
    logic        mem_rvalid   = 1'b0;
    logic [63:0] mem_rdata    = '0;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [4:0]  rd;
        logic [63:0] data;
        logic [1:0]  err;
    } rsp_t;
    rsp_t exp_q[$];

    load_store_unit_if #(.XLEN(32), .ADDR_W(32)) b32 ();
    load_store_unit_if #(.XLEN(64), .ADDR_W(32)) b64 ();

    load_store_unit #(.XLEN(32), .ADDR_W(32), .TIMEOUT(8)) u_lsu32 (.clk(clk), .rst_n(rst_n), .bus(b32));
    load_store_unit #(.XLEN(64), .ADDR_W(32)) u_lsu64 (.clk(clk), .rst_n(rst_n), .bus(b64));

    assign b32.req_valid    = req_valid & ~sel64;
    assign b32.req_is_store = req_is_store;
    assign b32.req_funct3   = req_funct3;
    assign b32.req_addr     = req_addr;
    assign b32.req_wdata    = req_wdata[31:0];
    assign b32.req_rd       = req_rd;
    assign b32.mem_ready    = mem_ready & ~sel64;
    assign b32.mem_rvalid   = mem_rvalid & ~sel64;
    assign b32.mem_rdata    = mem_rdata[31:0];

    assign b64.req_valid    = req_valid & sel64;
    assign b64.req_is_store = req_is_store;
    assign b64.req_funct3   = req_funct3;
    assign b64.req_addr     = req_addr;
    assign b64.req_wdata    = req_wdata;
    assign b64.req_rd       = req_rd;
    assign b64.mem_ready    = mem_ready & sel64;
    assign b64.mem_rvalid   = mem_rvalid & sel64;
    assign b64.mem_rdata    = mem_rdata;

    logic        o_req_ready, o_mem_valid, o_mem_we, o_rsp_valid;
    logic [31:0] o_mem_addr;
    logic [7:0]  o_mem_wstrb;
    logic [63:0] o_mem_wdata, o_rsp_data;
    logic [4:0]  o_rsp_rd;
    logic [1:0]  o_rsp_err;

    assign o_req_ready = sel64 ? b64.req_ready : b32.req_ready;
    assign o_mem_valid = sel64 ? b64.mem_valid : b32.mem_valid;
    assign o_mem_we    = sel64 ? b64.mem_we    : b32.mem_we;
    assign o_mem_addr  = sel64 ? b64.mem_addr  : b32.mem_addr;
    assign o_mem_wstrb = sel64 ? b64.mem_wstrb : {4'b0, b32.mem_wstrb};
    assign o_mem_wdata = sel64 ? b64.mem_wdata : {32'b0, b32.mem_wdata};
    assign o_rsp_valid = sel64 ? b64.rsp_valid : b32.rsp_valid;
    assign o_rsp_rd    = sel64 ? b64.rsp_rd    : b32.rsp_rd;
    assign o_rsp_data  = sel64 ? b64.rsp_data  : {32'b0, b32.rsp_data};
    assign o_rsp_err   = sel64 ? b64.rsp_err   : b32.rsp_err;

    // Byte-wise reference for a load: pick bytes at the offset, then fill upward by sign or zero.
    function automatic logic [63:0] ref_load(input logic [2:0] f3, input int off,
                                             input logic [63:0] word, input int xlen);
        logic [63:0] r;
        int          n;
        bit          neg;
        r = '0;
        n = 1 << f3[1:0];
        for (int i = 0; i < n; i++) r[8*i +: 8] = word[8*(off+i) +: 8];
        neg = !f3[2] && r[8*n-1];
        for (int i = n; i < xlen / 8; i++) r[8*i +: 8] = neg ? 8'hFF : 8'h00;
        return r;
    endfunction

    // Response monitor: every rsp_valid pulse must match the oldest expected entry.
    always @(negedge clk) begin
        if (rst_n && o_rsp_valid === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL rsp_unexpected: got rd=%0d data=%h err=%0d want no response",
                         o_rsp_rd, o_rsp_data, o_rsp_err);
            end else begin
                rsp_t e;
                e = exp_q.pop_front();
                if ({o_rsp_rd, o_rsp_data, o_rsp_err} !== {e.rd, e.data, e.err}) begin
                    bad++;
                    $display("FAIL rsp: got rd=%0d data=%h err=%0d want rd=%0d data=%h err=%0d",
                             o_rsp_rd, o_rsp_data, o_rsp_err, e.rd, e.data, e.err);
                end
            end
        end
    end

    task automatic issue(input bit st, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [63:0] wd, input logic [4:0] rd);
        int n = 0;
        while (o_req_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (o_req_ready !== 1'b1) begin
            bad++;
            $display("FAIL req_ready_wait: got %b want 1", o_req_ready);
        end
        req_is_store = st;
        req_funct3   = f3;
        req_addr     = addr;
        req_wdata    = wd;
        req_rd       = rd;
        req_valid    = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    // Legal access: check the memory request each cycle it waits, then return read data.
    task automatic run_txn(input string name, input bit st, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [63:0] wd, input logic [4:0] rd,
                           input logic [63:0] rdata, input int lat, input logic [31:0] e_addr,
                           input logic [7:0] e_strb, input logic [63:0] e_wdata,
                           input logic [63:0] e_data);
        exp_q.push_back('{rd: (st ? 5'd0 : rd), data: (st ? 64'd0 : e_data), err: 2'd0});
        issue(st, f3, addr, wd, rd);
        for (int c = 0; c <= lat; c++) begin
            total++;
            if ({o_mem_valid, o_mem_addr, o_mem_we, o_mem_wstrb, o_mem_wdata} !==
                {1'b1, e_addr, st, e_strb, e_wdata}) begin
                bad++;
                $display("FAIL %s mem_req: got v=%b a=%h we=%b s=%h d=%h want v=1 a=%h we=%b s=%h d=%h",
                         name, o_mem_valid, o_mem_addr, o_mem_we, o_mem_wstrb, o_mem_wdata,
                         e_addr, st, e_strb, e_wdata);
            end
            if (c == lat) mem_ready = 1'b1;
            @(negedge clk);
        end
        mem_ready  = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = rdata;
        total++;
        if (o_mem_valid !== 1'b0) begin
            bad++;
            $display("FAIL %s mem_valid_drop: got %b want 0", name, o_mem_valid);
        end
        @(negedge clk);
        mem_rvalid = 1'b0;
        total++;
        if (o_rsp_valid !== 1'b1) begin
            bad++;
            $display("FAIL %s rsp_latency: got rsp_valid=%b want 1", name, o_rsp_valid);
        end
        @(negedge clk);
    endtask

    // Rejected access: no memory traffic, response in the cycle after acceptance.
    task automatic err_txn(input string name, input bit st, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [4:0] rd, input logic [1:0] err);
        exp_q.push_back('{rd: (st ? 5'd0 : rd), data: 64'd0, err: err});
        issue(st, f3, addr, 64'h5A5A5A5A5A5A5A5A, rd);
        total++;
        if (o_mem_valid !== 1'b0 || o_rsp_valid !== 1'b1) begin
            bad++;
            $display("FAIL %s err_path: got mem_valid=%b rsp_valid=%b want 0 1",
                     name, o_mem_valid, o_rsp_valid);
        end
        @(negedge clk);
        total++;
        if (o_req_ready !== 1'b1 || o_rsp_valid !== 1'b0) begin
            bad++;
            $display("FAIL %s err_return: got req_ready=%b rsp_valid=%b want 1 0",
                     name, o_req_ready, o_rsp_valid);
        end
    endtask

    task automatic test_reset;
        #1 rst_n = 1'b0;
        #1;
        for (int s = 0; s < 2; s++) begin
            sel64 = (s == 1);
            #1;
            total++;
            if ({o_req_ready, o_mem_valid, o_mem_we, o_mem_addr, o_mem_wstrb, o_mem_wdata,
                 o_rsp_valid, o_rsp_rd, o_rsp_data, o_rsp_err} !== {1'b1, 1'b0, 1'b0, 32'h0, 8'h0,
                 64'h0, 1'b0, 5'h0, 64'h0, 2'h0}) begin
                bad++;
                $display("FAIL reset_outputs(xlen64=%0d): got ready=%b mv=%b rv=%b addr=%h want ready=1 rest 0",
                         s, o_req_ready, o_mem_valid, o_rsp_valid, o_mem_addr);
            end
        end
        sel64 = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic;
        run_txn("lb_0x103", 0, 3'b000, 32'h103, 64'h0, 5'd5, 64'h80FF1234, 0,
                32'h100, 8'h0, 64'h0, 64'hFFFFFF80);
        run_txn("sh_0x202", 1, 3'b001, 32'h202, 64'h0000ABCD, 5'd7, 64'h0, 2,
                32'h200, 8'b1100, 64'hABCD0000, 64'h0);
        run_txn("sb_0x501", 1, 3'b000, 32'h501, 64'h12345678, 5'd9, 64'h0, 1,
                32'h500, 8'b0010, 64'h00007800, 64'h0);
        run_txn("sw_0x504", 1, 3'b010, 32'h504, 64'hCAFEF00D, 5'd1, 64'h0, 0,
                32'h504, 8'b1111, 64'hCAFEF00D, 64'h0);
    endtask

    task automatic test_errors;
        err_txn("lw_misaligned", 0, 3'b010, 32'h101, 5'd1, 2'd1);
        err_txn("lh_misaligned", 0, 3'b001, 32'h201, 5'd2, 2'd1);
        err_txn("sw_misaligned", 1, 3'b010, 32'h102, 5'd3, 2'd1);
        err_txn("ld_on_xlen32",  0, 3'b011, 32'h100, 5'd4, 2'd3);
        err_txn("illegal_prio",  0, 3'b011, 32'h101, 5'd5, 2'd3);
        err_txn("store_f3_100",  1, 3'b100, 32'h100, 5'd6, 2'd3);
    endtask

    task automatic test_load_model;
        for (int i = 0; i < 5; i++) begin
            logic [2:0] f3;
            int         sz;
            f3 = (i < 3) ? 3'(i) : 3'(i + 1);
            sz = 1 << f3[1:0];
            for (int off = 0; off < 4; off += sz) begin
                logic [63:0] word;
                word = {32'h0, $urandom()};
                run_txn("load_model", 0, f3, 32'h600 + 32'(off), 64'h0, 5'(i * 4 + off + 1),
                        word, off & 1, 32'h600, 8'h0, 64'h0, ref_load(f3, off, word, 32));
            end
        end
    endtask

    task automatic test_timeout;
        int cyc = 0;
        exp_q.push_back('{rd: 5'd11, data: 64'd0, err: 2'd2});
        issue(0, 3'b010, 32'h300, 64'h0, 5'd11);
        while (o_mem_valid === 1'b1 && cyc < 40) begin
            cyc++;
            mem_ready = (cyc == 8);
            @(negedge clk);
        end
        mem_ready = 1'b0;
        total++;
        if (cyc != 8) begin
            bad++;
            $display("FAIL timeout_mem_valid_cycles: got %0d want 8", cyc);
        end
        total++;
        if (o_rsp_valid !== 1'b1) begin
            bad++;
            $display("FAIL timeout_rsp: got rsp_valid=%b want 1", o_rsp_valid);
        end
        @(negedge clk);
        mem_rvalid = 1'b1;
        mem_rdata  = 64'hFFFFFFFF;
        @(negedge clk);
        mem_rvalid = 1'b0;
        @(negedge clk);
        total++;
        if (o_req_ready !== 1'b1) begin
            bad++;
            $display("FAIL timeout_recover: got req_ready=%b want 1", o_req_ready);
        end
        run_txn("after_timeout", 0, 3'b010, 32'h304, 64'h0, 5'd12, 64'h11223344, 1,
                32'h304, 8'h0, 64'h0, 64'h11223344);
    endtask

    task automatic test_xlen64;
        sel64 = 1'b1;
        @(negedge clk);
        run_txn("lwu64", 0, 3'b110, 32'h14, 64'h0, 5'd9, 64'hDEADBEEF_00000000, 0,
                32'h10, 8'h0, 64'h0, 64'h00000000_DEADBEEF);
        run_txn("sd64", 1, 3'b011, 32'h18, 64'h0123456789ABCDEF, 5'd3, 64'h0, 1,
                32'h18, 8'hFF, 64'h0123456789ABCDEF, 64'h0);
        run_txn("lw64_sext", 0, 3'b010, 32'h24, 64'h0, 5'd4, 64'h80000001_12345678, 0,
                32'h20, 8'h0, 64'h0, 64'hFFFFFFFF_80000001);
        run_txn("ld64", 0, 3'b011, 32'h28, 64'h0, 5'd6, 64'hFEDCBA9876543210, 0,
                32'h28, 8'h0, 64'h0, 64'hFEDCBA9876543210);
        run_txn("sb64_off5", 1, 3'b000, 32'h1D, 64'h11223344556677AA, 5'd2, 64'h0, 0,
                32'h18, 8'h20, 64'h0000AA0000000000, 64'h0);
        err_txn("ld64_misaligned", 0, 3'b011, 32'h21, 5'd8, 2'd1);
        sel64 = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_txn;
        issue(0, 3'b010, 32'h400, 64'h0, 5'd13);
        mem_ready = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0;
        total++;
        if (o_mem_valid !== 1'b0 || o_req_ready !== 1'b0) begin
            bad++;
            $display("FAIL mid_in_wait: got mem_valid=%b req_ready=%b want 0 0", o_mem_valid, o_req_ready);
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({o_req_ready, o_mem_valid, o_rsp_valid, o_mem_we, o_mem_addr} !==
            {1'b1, 1'b0, 1'b0, 1'b0, 32'h0}) begin
            bad++;
            $display("FAIL mid_reset_outputs: got ready=%b mv=%b rv=%b we=%b addr=%h want 1 0 0 0 0",
                     o_req_ready, o_mem_valid, o_rsp_valid, o_mem_we, o_mem_addr);
        end
        @(negedge clk);
        rst_n      = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata  = 64'h0BADF00D;
        @(negedge clk);
        mem_rvalid = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (o_req_ready !== 1'b1) begin
            bad++;
            $display("FAIL mid_reset_ready: got %b want 1", o_req_ready);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_errors();
        test_load_model();
        test_timeout();
        test_xlen64();
        test_reset_mid_txn();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion want finish before 200000");
        $fatal(1, "watchdog expired");
    end
endmodule
